mem_space_ctrl: RTL and testbench

- Sequential, parametrised memory-space controller for the MSP430 model. It replaces the purely combinational address decode and read mux.
- Decodes a request address into SFR / 8-bit peripheral / 16-bit peripheral / RAM / unused / ROM regions. Region bounds are parameters.
- Holds RAM internally, reads ROM through an external port and forwards peripheral accesses over a wait-state handshake bus.
- Performs byte-lane handling, flags illegal accesses and returns a one-cycle ack with read data.

---
 rtl/mem_space_ctrl_if.sv | 31 +++
 rtl/mem_space_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_space_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_space_ctrl_if.sv
// rtl/mem_space_ctrl_if.sv - CPU, ROM and peripheral bus signals of the MSP430 memory-space controller
interface mem_space_ctrl_if #(parameter int ROM_AW = 13);
  logic              req;
  logic [15:0]       MAB_in;
  logic [15:0]       MDB_in;
  logic              MW;
  logic              BW;
  logic [15:0]       MDB_out;
  logic              ack;
  logic              err;
  logic [15:0]       err_addr;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              per_req;
  logic [15:0]       per_addr;
  logic [15:0]       per_wdata;
  logic              per_we;
  logic [1:0]        per_be;
  logic              per_rdy;
  logic [15:0]       per_rdata;

  modport master (
    output req, MAB_in, MDB_in, MW, BW, rom_data, per_rdy, per_rdata,
    input  MDB_out, ack, err, err_addr, rom_addr, per_req, per_addr, per_wdata, per_we, per_be
  );

  modport slave (
    input  req, MAB_in, MDB_in, MW, BW, rom_data, per_rdy, per_rdata,
    output MDB_out, ack, err, err_addr, rom_addr, per_req, per_addr, per_wdata, per_we, per_be
  );
endinterface

// File: rtl/mem_space_ctrl.sv
// rtl/mem_space_ctrl.sv - MSP430 memory-space controller: region decode, internal RAM, ROM port, peripheral handshake
module mem_space_ctrl #(
  parameter int unsigned UB_SFR      = 'h0010,
  parameter int unsigned UB_PER8     = 'h0100,
  parameter int unsigned UB_PER16    = 'h0200,
  parameter int unsigned UB_RAM      = 'h0400,
  parameter int unsigned UB_UNUSED   = 'hC000,
  parameter int unsigned PER_TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  mem_space_ctrl_if.slave bus
);
  localparam int unsigned RAM_WORDS = (UB_RAM - UB_PER16) / 2;
  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam int unsigned ROM_AW    = $clog2((32'h10000 - UB_UNUSED) / 2);
  localparam int unsigned CNT_W     = $clog2(PER_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM, PER, RESP} state_t;
  typedef enum logic [2:0] {RG_SFR, RG_PER8, RG_PER16, RG_RAM, RG_UNUSED, RG_ROM} region_t;

  function automatic region_t decode(input logic [15:0] a);
    if (32'(a) < UB_SFR)    return RG_SFR;
    if (32'(a) < UB_PER8)   return RG_PER8;
    if (32'(a) < UB_PER16)  return RG_PER16;
    if (32'(a) < UB_RAM)    return RG_RAM;
    if (32'(a) < UB_UNUSED) return RG_UNUSED;
    return RG_ROM;
  endfunction

  // Byte reads return the addressed lane zero-extended; odd address selects the high byte.
  function automatic logic [15:0] pick_lane(input logic [15:0] w, input logic bw, input logic hi);
    if (!bw) return w;
    return {8'h00, hi ? w[15:8] : w[7:0]};
  endfunction

  state_t             state;
  region_t            region_q;
  logic [15:0]        addr_q;
  logic [15:0]        wdata_q;
  logic               mw_q;
  logic               bw_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [15:0]        rdata;
  logic               ack_r;
  logic               err_r;
  logic [15:0]        err_addr_r;
  logic               per_req_r;
  logic [15:0]        per_addr_r;
  logic [15:0]        per_wdata_r;
  logic               per_we_r;
  logic [1:0]         per_be_r;
  logic [15:0]        ram [RAM_WORDS];

  region_t            rgn_in;
  logic               to_per;
  logic               illegal;
  logic [RAM_AW-1:0]  ram_idx;
  logic [15:0]        mem_word;

  assign rgn_in  = decode(bus.MAB_in);
  assign to_per  = (rgn_in == RG_SFR) || (rgn_in == RG_PER16) || (rgn_in == RG_PER8 && bus.BW);
  assign illegal = (region_q == RG_UNUSED) || (region_q == RG_ROM && mw_q) ||
                   (region_q == RG_PER8 && !bw_q);
  assign ram_idx = RAM_AW'((addr_q - 16'(UB_PER16)) >> 1);
  assign mem_word = (region_q == RG_RAM) ? ram[ram_idx] : bus.rom_data;

  assign bus.rom_addr  = ROM_AW'((addr_q - 16'(UB_UNUSED)) >> 1);
  assign bus.MDB_out   = rdata;
  assign bus.ack       = ack_r;
  assign bus.err       = err_r;
  assign bus.err_addr  = err_addr_r;
  assign bus.per_req   = per_req_r;
  assign bus.per_addr  = per_addr_r;
  assign bus.per_wdata = per_wdata_r;
  assign bus.per_we    = per_we_r;
  assign bus.per_be    = per_be_r;

  always_ff @(posedge clk) begin
    if (!rst && state == MEM && region_q == RG_RAM && mw_q) begin
      if (!bw_q)          ram[ram_idx]       <= wdata_q;
      else if (addr_q[0]) ram[ram_idx][15:8] <= wdata_q[7:0];
      else                ram[ram_idx][7:0]  <= wdata_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      per_req_r  <= 1'b0;
      rdata      <= 16'h0000;
      err_addr_r <= 16'h0000;
      wait_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.req) begin
          addr_q   <= bus.MAB_in;
          wdata_q  <= bus.MDB_in;
          mw_q     <= bus.MW;
          bw_q     <= bus.BW;
          region_q <= rgn_in;
          if (to_per) begin
            state       <= PER;
            per_req_r   <= 1'b1;
            per_addr_r  <= bus.BW ? bus.MAB_in : {bus.MAB_in[15:1], 1'b0};
            per_we_r    <= bus.MW;
            per_be_r    <= bus.BW ? {bus.MAB_in[0], ~bus.MAB_in[0]} : 2'b11;
            per_wdata_r <= bus.BW ? {2{bus.MDB_in[7:0]}} : bus.MDB_in;
            wait_cnt    <= '0;
          end else begin
            state <= MEM;
          end
        end
        MEM: begin
          state <= RESP;
          ack_r <= 1'b1;
          err_r <= illegal;
          if (illegal) begin
            rdata      <= 16'h0000;
            err_addr_r <= addr_q;
          end else begin
            rdata <= mw_q ? 16'h0000 : pick_lane(mem_word, bw_q, addr_q[0]);
          end
        end
        // A ready in the last allowed cycle still wins over the timeout.
        PER: if (bus.per_rdy) begin
          state     <= RESP;
          per_req_r <= 1'b0;
          ack_r     <= 1'b1;
          err_r     <= 1'b0;
          rdata     <= mw_q ? 16'h0000 : pick_lane(bus.per_rdata, bw_q, addr_q[0]);
        end else if (wait_cnt == CNT_W'(PER_TIMEOUT - 1)) begin
          state      <= RESP;
          per_req_r  <= 1'b0;
          ack_r      <= 1'b1;
          err_r      <= 1'b1;
          rdata      <= 16'h0000;
          err_addr_r <= addr_q;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        RESP: begin
          state <= IDLE;
          ack_r <= 1'b0;
          err_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_space_ctrl.sv
// tb/tb_mem_space_ctrl.sv - randomized self-checking bench for mem_space_ctrl against a byte-level memory-map model
module tb_mem_space_ctrl;
  localparam int ROM_AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0]  ram_m [512];
  logic [15:0] err_addr_m = 16'h0000;

  always #5 clk = ~clk;

  mem_space_ctrl_if #(.ROM_AW(ROM_AW)) bus ();
  mem_space_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [15:0] rom_word(input logic [ROM_AW-1:0] wa);
    return {3'b101, wa} ^ 16'h3C3C;
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete access; n = cycles per_rdy stays low after per_req rises (>=15 means timeout).
  task automatic access(input logic [15:0] a, input logic [15:0] d, input logic mw, input logic bw,
                        input int n, input logic [15:0] prd);
    logic [15:0] wa, exp_rd, w, exp_paddr, exp_pwd;
    logic [1:0]  exp_be;
    logic [8:0]  bo;
    logic [ROM_AW-1:0] exp_ra;
    bit per, err, rom_rd;
    int lat;
    wa = a & 16'hFFFE;
    per = 0; err = 0; rom_rd = 0; exp_rd = 16'h0000; lat = 2; exp_ra = '0;
    if (a < 16'h0010 || (a >= 16'h0100 && a < 16'h0200)) per = 1;
    else if (a < 16'h0100) begin
      if (bw) per = 1; else err = 1;
    end else if (a < 16'h0400) begin
      bo = 9'(a - 16'h0200);
      if (!mw) exp_rd = bw ? {8'h00, ram_m[bo]} : {ram_m[bo | 9'd1], ram_m[bo & 9'h1FE]};
      else if (bw) ram_m[bo] = d[7:0];
      else begin
        ram_m[bo & 9'h1FE] = d[7:0];
        ram_m[bo | 9'd1]   = d[15:8];
      end
    end else if (a < 16'hC000) err = 1;
    else if (mw) err = 1;
    else begin
      rom_rd = 1;
      exp_ra = ROM_AW'((wa - 16'hC000) / 2);
      w = rom_word(exp_ra);
      exp_rd = bw ? {8'h00, a[0] ? w[15:8] : w[7:0]} : w;
    end
    if (per) begin
      lat = (n < 15) ? n + 2 : 16;
      if (n >= 15) err = 1;
      else if (!mw) exp_rd = bw ? {8'h00, a[0] ? prd[15:8] : prd[7:0]} : prd;
    end
    if (err) begin
      exp_rd = 16'h0000;
      err_addr_m = a;
    end
    exp_paddr = bw ? a : wa;
    exp_be    = bw ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    exp_pwd   = bw ? {d[7:0], d[7:0]} : d;

    bus.req = 1'b1; bus.MAB_in = a; bus.MDB_in = d; bus.MW = mw; bus.BW = bw;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req = 1'b0;
        bus.MAB_in = 16'($urandom);
        bus.MDB_in = 16'($urandom);
      end
      check_eq("ack", 32'(bus.ack), 32'(c == lat));
      check_eq("per_req", 32'(bus.per_req), 32'(per && c < lat));
      if (per && c < lat) begin
        check_eq("per_addr", 32'(bus.per_addr), 32'(exp_paddr));
        check_eq("per_be", 32'(bus.per_be), 32'(exp_be));
        check_eq("per_we", 32'(bus.per_we), 32'(mw));
        check_eq("per_wdata", 32'(bus.per_wdata), 32'(exp_pwd));
      end
      if (c == lat) begin
        check_eq("err", 32'(bus.err), 32'(err));
        check_eq("err_addr", 32'(bus.err_addr), 32'(err_addr_m));
        if (err || !mw) check_eq("MDB_out", 32'(bus.MDB_out), 32'(exp_rd));
        if (rom_rd) check_eq("rom_addr", 32'(bus.rom_addr), 32'(exp_ra));
      end
      bus.per_rdy   = per && (c == n + 1);
      bus.per_rdata = (per && c == n + 1) ? prd : 16'($urandom);
    end
    @(negedge clk);
    bus.per_rdy = 1'b0;
    check_eq("ack_pulse", 32'(bus.ack), 32'd0);
  endtask

  logic [15:0] bnd [10] = '{16'h000F, 16'h0010, 16'h00FF, 16'h0100, 16'h01FF,
                            16'h03FF, 16'h0400, 16'hBFFF, 16'hC000, 16'hFFFF};

  initial begin
    logic [15:0] a, exp;
    bus.req = 1'b0; bus.MAB_in = 16'h0000; bus.MDB_in = 16'h0000; bus.MW = 1'b0; bus.BW = 1'b0;
    bus.per_rdy = 1'b0; bus.per_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_per_req", 32'(bus.per_req), 32'd0);
    check_eq("rst_MDB_out", 32'(bus.MDB_out), 32'd0);
    check_eq("rst_err_addr", 32'(bus.err_addr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) access(16'(16'h0200 + 2 * i), 16'($urandom), 1'b1, 1'b0, 0, 16'h0);

    access(16'h0200, 16'hBEEF, 1'b1, 1'b0, 0, 16'h0);
    access(16'h0200, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
    access(16'h0301, 16'h0012, 1'b1, 1'b1, 0, 16'h0);
    access(16'h0300, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
    access(16'h0301, 16'h0000, 1'b0, 1'b1, 0, 16'h0);
    access(16'h0120, 16'h0000, 1'b0, 1'b0, 3, 16'h5A5A);
    access(16'h0150, 16'h1234, 1'b1, 1'b0, 16, 16'h0);
    access(16'h1000, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
    access(16'hFFFE, 16'hAAAA, 1'b1, 1'b0, 0, 16'h0);
    access(16'h0020, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
    access(16'hFFFE, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
    access(16'h0130, 16'h0000, 1'b0, 1'b0, 0, 16'hC3A5);
    access(16'h0132, 16'h0000, 1'b0, 1'b0, 14, 16'h7E81);
    access(16'h0134, 16'h0000, 1'b0, 1'b0, 15, 16'h7E81);
    for (int i = 0; i < 10; i++) access(bnd[i], 16'($urandom), 1'b0, 1'b1, 1, 16'($urandom));

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 16'(16'h0200 + $urandom_range(0, 511));
        4:          a = 16'($urandom_range(0, 15));
        5:          a = 16'($urandom_range(16, 255));
        6:          a = 16'($urandom_range(256, 511));
        7:          a = 16'($urandom_range(16'h0400, 16'hBFFF));
        default:    a = 16'($urandom_range(16'hC000, 16'hFFFF));
      endcase
      access(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 16)), 16'($urandom));
    end

    // A req held into the MEM cycle must not start a second access.
    exp = {ram_m[1], ram_m[0]};
    bus.req = 1'b1; bus.MAB_in = 16'h0200; bus.MW = 1'b0; bus.BW = 1'b0;
    @(negedge clk);
    bus.MAB_in = 16'h1000;
    check_eq("mem_ack_early", 32'(bus.ack), 32'd0);
    @(negedge clk);
    bus.req = 1'b0;
    check_eq("mem_ack", 32'(bus.ack), 32'd1);
    check_eq("mem_err", 32'(bus.err), 32'd0);
    check_eq("mem_MDB_out", 32'(bus.MDB_out), 32'(exp));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("no_second_ack", 32'(bus.ack), 32'd0);
    end

    access(16'h1000, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
    bus.req = 1'b1; bus.MAB_in = 16'h0180; bus.MW = 1'b0; bus.BW = 1'b0;
    @(negedge clk);
    bus.req = 1'b0;
    check_eq("per_req_pre_rst", 32'(bus.per_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_addr_m = 16'h0000;
    check_eq("rst_per_req_drop", 32'(bus.per_req), 32'd0);
    check_eq("rst_per_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_per_MDB_out", 32'(bus.MDB_out), 32'd0);
    check_eq("rst_per_err_addr", 32'(bus.err_addr), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("rst_no_ack", 32'(bus.ack), 32'd0);
      check_eq("rst_no_per_req", 32'(bus.per_req), 32'd0);
    end
    access(16'h0200, 16'h0000, 1'b0, 1'b0, 0, 16'h0);
    access(16'h0140, 16'h0000, 1'b0, 1'b1, 2, 16'h9B6D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
